// File: rtl/data_mem_bank.sv
// Multi-channel word memory: each channel runs its own request FSM with a fixed
// request-to-ready latency; a host preload port writes the shared array directly.
module data_mem_bank #(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 8,
    parameter int CHANNELS  = 4,
    parameter int LATENCY   = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [CHANNELS-1:0]  read_valid,
    input  logic [ADDR_BITS-1:0] read_address [CHANNELS],
    output logic [CHANNELS-1:0]  read_ready,
    output logic [DATA_BITS-1:0] read_data [CHANNELS],
    input  logic [CHANNELS-1:0]  write_valid,
    input  logic [ADDR_BITS-1:0] write_address [CHANNELS],
    input  logic [DATA_BITS-1:0] write_data [CHANNELS],
    output logic [CHANNELS-1:0]  write_ready,
    input  logic                 load_enable,
    input  logic [ADDR_BITS-1:0] load_address,
    input  logic [DATA_BITS-1:0] load_data
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP, DRAIN} state_t;

    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    logic [DATA_BITS-1:0] mem_array [2**ADDR_BITS];

    state_t               state_q [CHANNELS];
    state_t               state_d [CHANNELS];
    logic [3:0]           cnt_q   [CHANNELS];
    logic [3:0]           cnt_d   [CHANNELS];
    logic [DATA_BITS-1:0] rdata_q [CHANNELS];
    logic [DATA_BITS-1:0] rdata_d [CHANNELS];
    logic [CHANNELS-1:0]  is_wr_q, is_wr_d;
    logic [CHANNELS-1:0]  rd_rdy_q, rd_rdy_d;
    logic [CHANNELS-1:0]  wr_rdy_q, wr_rdy_d;
    logic [CHANNELS-1:0]  acc_wr;

    always_comb begin
        is_wr_d  = is_wr_q;
        rd_rdy_d = '0;
        wr_rdy_d = '0;
        acc_wr   = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            state_d[c] = state_q[c];
            cnt_d[c]   = cnt_q[c];
            rdata_d[c] = rdata_q[c];
            case (state_q[c])
                IDLE: begin
                    // A read wins over a simultaneous write; the write stays pending.
                    if (!reset && !load_enable && (read_valid[c] || write_valid[c])) begin
                        is_wr_d[c] = !read_valid[c];
                        acc_wr[c]  = !read_valid[c];
                        if (read_valid[c]) begin
                            rdata_d[c] = mem_array[read_address[c]];
                        end
                        cnt_d[c] = LAT_M1;
                        if (LATENCY == 1) begin
                            state_d[c]  = RESP;
                            rd_rdy_d[c] = read_valid[c];
                            wr_rdy_d[c] = !read_valid[c];
                        end else begin
                            state_d[c] = BUSY;
                        end
                    end
                end
                BUSY: begin
                    cnt_d[c] = cnt_q[c] - 4'd1;
                    if (cnt_q[c] <= 4'd1) begin
                        cnt_d[c]    = '0;
                        state_d[c]  = RESP;
                        rd_rdy_d[c] = !is_wr_q[c];
                        wr_rdy_d[c] = is_wr_q[c];
                    end
                end
                RESP: state_d[c] = DRAIN;
                DRAIN: begin
                    if (is_wr_q[c] ? !write_valid[c] : !read_valid[c]) begin
                        state_d[c] = IDLE;
                    end
                end
                default: state_d[c] = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < CHANNELS; c++) begin
                state_q[c] <= IDLE;
                cnt_q[c]   <= '0;
                rdata_q[c] <= '0;
            end
            is_wr_q  <= '0;
            rd_rdy_q <= '0;
            wr_rdy_q <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                state_q[c] <= state_d[c];
                cnt_q[c]   <= cnt_d[c];
                rdata_q[c] <= rdata_d[c];
            end
            is_wr_q  <= is_wr_d;
            rd_rdy_q <= rd_rdy_d;
            wr_rdy_q <= wr_rdy_d;
        end
    end

    // Array is never reset; ascending loop order lets the highest channel win a collision.
    always_ff @(posedge clk) begin
        if (load_enable) begin
            mem_array[load_address] <= load_data;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (acc_wr[c]) begin
                    mem_array[write_address[c]] <= write_data[c];
                end
            end
        end
    end

    assign read_ready  = rd_rdy_q;
    assign write_ready = wr_rdy_q;
    assign read_data   = rdata_q;

endmodule

// File: doc/data_mem_bank.md
DATA_MEM_BANK -- requirements
Module: data_mem_bank

Interface
REQ-001 Parameter ADDR_BITS, default 8: address width; array depth is 2**ADDR_BITS words.
REQ-002 Parameter DATA_BITS, default 8: word width.
REQ-003 Parameter CHANNELS, default 4: number of independent request channels.
REQ-004 Parameter LATENCY, default 2, legal 1..15: cycles from request acceptance to ready.
REQ-005 One clock; reset is asynchronous and active-high.
REQ-006 clk  in  1  single clock, all state on rising edge.
REQ-007 reset  in  1  asynchronous, active-high.
REQ-008 read_valid  in  CHANNELS  per-channel read request.
REQ-009 read_address  in  CHANNELS x ADDR_BITS  per-channel read address (unpacked array).
REQ-010 read_ready  out  CHANNELS  per-channel read completion.
REQ-011 read_data  out  CHANNELS x DATA_BITS  per-channel read data (unpacked array).
REQ-012 write_valid  in  CHANNELS  per-channel write request.
REQ-013 write_address  in  CHANNELS x ADDR_BITS  per-channel write address (unpacked array).
REQ-014 write_data  in  CHANNELS x DATA_BITS  per-channel write data (unpacked array).
REQ-015 write_ready  out  CHANNELS  per-channel write completion.
REQ-016 load_enable  in  1  host preload strobe.
REQ-017 load_address  in  ADDR_BITS  preload address.
REQ-018 load_data  in  DATA_BITS  preload data.

Function
REQ-019 Each channel SHALL run an independent FSM: IDLE, BUSY, RESP, DRAIN.
REQ-020 IDLE: on an edge with load_enable low and read_valid or write_valid high, channel SHALL accept, load a down-counter with LATENCY-1, and go to BUSY (RESP directly when LATENCY=1).
REQ-021 If read_valid and write_valid are both high in IDLE, the read SHALL be accepted and the write left pending.
REQ-022 Read data SHALL be sampled from the array at the acceptance edge and held in a per-channel register until the next acceptance.
REQ-023 A write SHALL commit to the array at the acceptance edge.
REQ-024 BUSY: counter decrements each cycle; at zero, go to RESP.
REQ-025 RESP: exactly one cycle of read_ready (read) or write_ready (write) high with read_data valid; then DRAIN.
REQ-026 Request-to-ready latency SHALL be exactly LATENCY cycles: accepted at edge N, ready high in the cycle after edge N+LATENCY-1.
REQ-027 DRAIN: stay until the served valid is low, then IDLE; no request is re-served while its valid is held.
REQ-028 Same-edge writes to one address from several channels: highest channel index SHALL win.
REQ-029 Read accepted on the same edge as a write to its address SHALL return the pre-write value.
REQ-030 load_enable high: array[load_address] <= load_data; no channel SHALL accept in that cycle; channels already in BUSY/RESP/DRAIN continue unaffected.
REQ-031 load write and channel write never coincide (REQ-030); load has priority by construction.
REQ-032 read_data SHALL hold its last value outside RESP; consumers sample only when read_ready is high.
REQ-033 Addresses use full ADDR_BITS; no wrap or range check needed.

Reset
REQ-034 On reset assertion, all FSMs SHALL go to IDLE asynchronously; read_ready, write_ready, counters and read_data registers SHALL be 0.
REQ-035 Array contents SHALL NOT be cleared by reset; in-flight transactions SHALL be dropped without a ready pulse, committed writes SHALL persist.
REQ-036 First acceptance SHALL be possible on the first rising edge after reset deasserts.

Verification
REQ-037 Preload addr 0..15 with 0..7,0..7; ch0 read addr 5, LATENCY=2 -> read_ready[0] one cycle, 2 cycles after accept, read_data[0]=5.
REQ-038 All 4 channels read addrs 1,2,3,4 same cycle -> 4 simultaneous ready pulses, data 1,2,3,4.
REQ-039 ch1 and ch3 write addr 16 values 0x0A and 0x0B same edge; later read 16 -> 0x0B.
REQ-040 ch0 write addr 8 value 0x55 while ch2 reads addr 8 same edge -> ch2 data=old 0; subsequent read -> 0x55.
REQ-041 ch0 holds read_valid 6 cycles -> exactly one read_ready pulse; drop valid 1 cycle, reassert -> second pulse.
REQ-042 Reset asserted while ch0 in BUSY -> ready outputs 0 immediately, no pulse; preloaded/written data still readable after reset.
